// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch (read-only) and the MEM stage (read/write).
// Optional macro ARB_TIMEOUT_EN adds an ISSUE-state watchdog that forces completion and raises a sticky arb_err.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy,
    output logic              arb_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              fetch_wins;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            arb_err_q, arb_err_d;
    logic            timeout;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Data side has priority unless fetch has been passed over STARVE_LIMIT times in a row.
    assign fetch_wins = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        owner_dm_d   = owner_dm_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        arb_err_d    = arb_err_q;
        to_cnt_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    if (fetch_wins) begin
                        owner_dm_d   = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        starve_cnt_d = '0;
                    end else begin
                        owner_dm_d  = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        if (if_req && (starve_cnt_q != 4'hF)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = DONE;
                    if (owner_dm_q) begin
                        dm_rdata_d = mem_we_q ? '0 : mem_rdata;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout) begin
                    // Give up on the memory so the pipeline keeps moving; all-ones marks the bad data.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    arb_err_d = 1'b1;
                    state_d   = DONE;
                    if (owner_dm_q) begin
                        dm_rdata_d = '1;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = '1;
                        if_done_d  = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!if_req) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_dm_q   <= 1'b0;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_dm_q   <= owner_dm_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    assign arb_err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_req & ~dm_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: agents push expected read data, a monitor pops on each done pulse.
// A grant checker predicts each arbitration winner from the starvation rule; a memory model supplies wait states.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_done, dm_done;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_if, stall_mem, busy, arb_err;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference memory image (updated when a write is issued) and the model's own array (updated on ack).
    logic [31:0] ref_arr [logic [31:0]];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : init_val(a);
    endfunction

    // Memory model: acks after wtarget wait cycles, tolerates reset by forgetting the transaction.
    int          force_wait = 0;
    bit          no_ack = 0;
    int          wcnt, wtarget;
    bit          in_txn = 0;
    int          ack_cyc = -10;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack = 1'b0;
                in_txn = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1;
                    wcnt = 0;
                    wtarget = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                    hold_addr = mem_addr;
                    hold_we = mem_we;
                    hold_wdata = mem_wdata;
                end else begin
                    chk("mem_addr_stable", mem_addr, hold_addr);
                    chk("mem_we_stable", mem_we, hold_we);
                    chk("mem_wdata_stable", mem_wdata, hold_wdata);
                end
                if (!no_ack && wcnt == wtarget) begin
                    mem_ack = 1'b1;
                    in_txn = 0;
                    ack_cyc = cyc;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                in_txn = 0;
            end
        end
    end

    // Scoreboard monitor.
    int          if_done_total = 0;
    int          dm_done_total = 0;
    logic [31:0] mon_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (if_done) begin
                if_done_total++;
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_done_unexpected: got a pulse, required none (t=%0t)", $time);
                end else begin
                    mon_exp = if_q.pop_front();
                    chk("if_rdata", if_rdata, mon_exp);
                end
                if (!no_ack) chk("if_done_latency", cyc, ack_cyc + 1);
            end
            if (dm_done) begin
                dm_done_total++;
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_done_unexpected: got a pulse, required none (t=%0t)", $time);
                end else begin
                    mon_exp = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, mon_exp);
                end
                if (!no_ack) chk("dm_done_latency", cyc, ack_cyc + 1);
            end
            chk("single_done", if_done & dm_done, 1'b0);
            chk("stall_if", stall_if, if_req & ~if_done);
            chk("stall_mem", stall_mem, dm_req & ~dm_done);
        end
    end

    // Grant checker: winner predicted from the request lines seen just before each new mem_req.
    logic        p_if = 0, p_dm = 0, p_we = 0, p_mreq = 0;
    logic [31:0] p_ia, p_da, p_wd;
    int          streak = 0;
    int          req_run = 0;
    int          last_req_len = 0;
    bit          g_new, g_dm;

    always @(negedge clk) begin
        if (rst) begin
            streak = 0; p_if = 0; p_dm = 0; p_mreq = 0; req_run = 0;
        end else begin
            g_new = mem_req && !p_mreq;
            g_dm = p_dm && !(p_if && streak == SL);
            if (g_new) begin
                if (!p_if && !p_dm) begin
                    checks++; errors++;
                    $display("FAIL spurious_grant: got mem_req with no request pending (t=%0t)", $time);
                end else begin
                    chk("grant_addr", mem_addr, g_dm ? p_da : p_ia);
                    chk("grant_we", mem_we, g_dm ? p_we : 1'b0);
                    if (g_dm && p_we) chk("grant_wdata", mem_wdata, p_wd);
                end
            end
            if (!p_if) streak = 0;
            else if (g_new && !g_dm) streak = 0;
            else if (g_new && g_dm && streak < 15) streak++;
            if (mem_req) req_run++;
            else if (req_run > 0) begin
                last_req_len = req_run;
                req_run = 0;
            end
            p_if = if_req; p_dm = dm_req; p_we = dm_we; p_mreq = mem_req;
            p_ia = if_addr; p_da = dm_addr; p_wd = dm_wdata;
        end
    end

    task automatic fetch_txn_exp(input logic [31:0] a, input logic [31:0] e, output int done_cyc);
        int n;
        if_addr = a;
        if_q.push_back(e);
        if_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_done && n < 400);
        if (!if_done) begin
            checks++; errors++;
            $display("FAIL fetch_wait: got no if_done within 400 cycles, required a pulse");
        end
        done_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_txn(input logic [31:0] a, output int done_cyc);
        fetch_txn_exp(a, ref_rd(a), done_cyc);
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, output int done_cyc);
        int n;
        dm_we = we; dm_addr = a; dm_wdata = wd;
        if (we) begin
            ref_arr[a] = wd;
            dm_q.push_back(32'h0);
        end else begin
            dm_q.push_back(ref_rd(a));
        end
        dm_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 400);
        if (!dm_done) begin
            checks++; errors++;
            $display("FAIL data_wait: got no dm_done within 400 cycles, required a pulse");
        end
        done_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int t0, dc, dc2, dm_before, n;
        rst = 1'b1;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        ref_arr[32'h8] = 32'h1234_ABCD;
        mem_arr[32'h8] = 32'h1234_ABCD;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_dones", {if_done, dm_done}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_arb_err", arb_err, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Fetch-only read with an immediate ack.
        force_wait = 0;
        t0 = cyc;
        fetch_txn(32'h8, dc);
        if_req = 0;
        chk("fetch_latency", dc - t0 + 1, 3);
        chk("fetch_rdata_direct", if_rdata, 32'h1234_ABCD);
        chk("fetch_req_len", last_req_len, 1);
        @(negedge clk);
        chk("fetch_stall_after", stall_if, 1'b0);
        @(posedge clk); #1;

        // Five wait states.
        force_wait = 5;
        t0 = cyc;
        fetch_txn(32'h30, dc);
        if_req = 0;
        chk("wait_latency", dc - t0 + 1, 8);
        chk("wait_req_len", last_req_len, 6);
        repeat (2) @(posedge clk); #1;

        // Simultaneous data write and fetch: data first, fetch three cycles after dm_done.
        force_wait = 0;
        fork
            begin data_txn(1'b1, 32'h10, 32'h55, dc2); dm_req = 0; end
            begin fetch_txn(32'h20, dc); if_req = 0; end
        join
        chk("simul_fetch_after_data", dc - dc2, 3);
        repeat (2) @(posedge clk); #1;

        // Starvation: data issued back to back while fetch waits.
        dm_before = dm_done_total;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    data_txn(1'($urandom_range(0, 1)), 32'h1000_0000 | (32'($urandom_range(0, 63)) << 2),
                             $urandom, dc2);
                end
                dm_req = 0;
            end
            begin
                fetch_txn(32'h40, dc);
                chk("starve_data_before_fetch", dm_done_total - dm_before, SL);
                if_req = 0;
            end
        join
        chk("starve_data_total", dm_done_total - dm_before, 6);
        repeat (2) @(posedge clk); #1;

        // Reset during the second ISSUE cycle; the held fetch must be re-served.
        force_wait = 5;
        fork
            begin fetch_txn(32'h44, dc); if_req = 0; end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!mem_req && n < 50);
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                chk("midrst_mem_req", mem_req, 1'b0);
                chk("midrst_busy", busy, 1'b0);
                chk("midrst_if_done", if_done, 1'b0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        repeat (2) @(posedge clk); #1;

        // Random traffic from both stages.
        force_wait = -1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    n = $urandom_range(0, 3);
                    if (n > 0) begin
                        if_req = 0;
                        repeat (n) @(posedge clk);
                        #1;
                    end
                    fetch_txn(32'($urandom_range(0, 1023)) << 2, dc);
                end
                if_req = 0;
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        dm_req = 0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    data_txn(1'($urandom_range(0, 1)), 32'h1000_0000 | (32'($urandom_range(0, 63)) << 2),
                             $urandom, dc2);
                end
                dm_req = 0;
            end
        join
        repeat (3) @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
        no_ack = 1;
        fetch_txn_exp(32'h80, 32'hFFFF_FFFF, dc);
        if_req = 0;
        chk("timeout_req_len", last_req_len, TO);
        chk("timeout_arb_err", arb_err, 1'b1);
        no_ack = 0;
        force_wait = 0;
        repeat (2) @(posedge clk); #1;
        fetch_txn(32'h84, dc);
        if_req = 0;
        chk("arb_err_sticky", arb_err, 1'b1);
        rst = 1'b1;
        #1;
        chk("arb_err_cleared", arb_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
`else
        chk("arb_err_tied", arb_err, 1'b0);
`endif

        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
